fp_mul_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754-style floating-point multiplier.
- Successor to the team's combinational half-precision multiplier.
- Adds generic exponent/mantissa widths, correct bias handling, round-to-nearest-even and special-value handling.
- Adds a 3-stage valid/ready pipeline; sits between operand issue logic and the FP result writeback.

---
 rtl/fp_mul_pkg.sv | 42 ++++
 rtl/fp_mul_pipe_unpack.sv | 31 +++
 rtl/fp_mul_pipe.sv | 170 +++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the pipelined floating-point multiplier: default
// widths, bias formula, operand classes, special-value constructors, flag bits.
package fp_mul_pkg;

    localparam int unsigned EXP_W_DEF = 5;
    localparam int unsigned MAN_W_DEF = 10;

    // Bit positions inside the optional 4-bit flag vector
    localparam int unsigned FLAG_W         = 4;
    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    function automatic int unsigned bias_of(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Constructors return a 64-bit container; callers truncate to their word width
    function automatic logic [63:0] inf_word(input logic sign, input int unsigned exp_w,
                                              input int unsigned man_w);
        logic [63:0] w;
        w = ((64'd1 << exp_w) - 64'd1) << man_w;
        w = w | (64'(sign) << (exp_w + man_w));
        return w;
    endfunction

    function automatic logic [63:0] nan_word(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] w;
        w = ((64'd1 << exp_w) - 64'd1) << man_w;
        w = w | (64'd1 << (man_w - 32'd1));
        return w;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_unpack.sv
// Combinational operand split and classification; denormals classify as zero.
module fp_unpack
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF,
    localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0]     op,
    output logic             sign_c,
    output logic [EXP_W-1:0] exp_c,
    output logic [MAN_W:0]   sig_c,
    output fp_class_e        cls_c
);

    logic [MAN_W-1:0] frac_c;

    always_comb begin
        sign_c = op[W-1];
        exp_c  = op[W-2 -: EXP_W];
        frac_c = op[MAN_W-1:0];
        sig_c  = {1'b1, frac_c};
        cls_c  = CLS_NORM;
        if (exp_c == '0) begin
            cls_c = CLS_ZERO;
        end else if (exp_c == '1) begin
            cls_c = (frac_c == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage valid/ready floating-point multiplier with round-to-nearest-even.
// Define FP_MUL_FLAGS_EN to add the out_flags {invalid, overflow, underflow, inexact} port.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF,
    localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef FP_MUL_FLAGS_EN
    output logic [FLAG_W-1:0] out_flags,
`endif
    output logic [W-1:0]      out_res
);

    localparam int unsigned BIAS    = bias_of(EXP_W);
    localparam int unsigned EW      = EXP_W + 2;
    localparam int unsigned SW      = MAN_W + 1;
    localparam int unsigned PW      = 2 * MAN_W + 2;
    localparam int unsigned EXP_MAX = (32'd1 << EXP_W) - 32'd1;

    // Single global advance: every stage moves or every stage holds
    logic adv_c;
    assign adv_c    = out_ready || !out_valid;
    assign in_ready = adv_c;

    logic             sa_c, sb_c;
    logic [EXP_W-1:0] ea_c, eb_c;
    logic [SW-1:0]    siga_c, sigb_c;
    fp_class_e        cla_c, clb_c;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .op     (in_a),
        .sign_c (sa_c),
        .exp_c  (ea_c),
        .sig_c  (siga_c),
        .cls_c  (cla_c)
    );

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .op     (in_b),
        .sign_c (sb_c),
        .exp_c  (eb_c),
        .sig_c  (sigb_c),
        .cls_c  (clb_c)
    );

    logic signed [EW-1:0] esum_c;
    assign esum_c = $signed(EW'(ea_c)) + $signed(EW'(eb_c)) - $signed(EW'(BIAS));

    logic                 v1, v2;
    logic                 s1_sign, s2_sign;
    logic signed [EW-1:0] s1_exp, s2_exp;
    logic [SW-1:0]        s1_ma, s1_mb;
    logic [PW-1:0]        s2_prod;
    fp_class_e            s1_cls_a, s1_cls_b, s2_cls_a, s2_cls_b;

    // S1 unpack register and S2 multiply register
    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
            s1_cls_a <= CLS_ZERO;
            s1_cls_b <= CLS_ZERO;
            v2       <= 1'b0;
            s2_sign  <= 1'b0;
            s2_exp   <= '0;
            s2_prod  <= '0;
            s2_cls_a <= CLS_ZERO;
            s2_cls_b <= CLS_ZERO;
        end else if (adv_c) begin
            v1       <= in_valid;
            s1_sign  <= sa_c ^ sb_c;
            s1_exp   <= esum_c;
            s1_ma    <= siga_c;
            s1_mb    <= sigb_c;
            s1_cls_a <= cla_c;
            s1_cls_b <= clb_c;
            v2       <= v1;
            s2_sign  <= s1_sign;
            s2_exp   <= s1_exp;
            s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
            s2_cls_a <= s1_cls_a;
            s2_cls_b <= s1_cls_b;
        end
    end

    logic [PW-2:0]        pn_c;
    logic signed [EW-1:0] en_c, ef_c;
    logic [MAN_W-1:0]     frac_c, fracr_c;
    logic                 guard_c, sticky_c, rnd_up_c, carry_c;
    logic                 ovf_c, unf_c;
    logic                 nan_c, inf_c, zero_c, normal_c;
    logic [W-1:0]         res_c;

    // S3 normalise, round to nearest even, apply special-value priority
    always_comb begin
        pn_c     = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
        en_c     = s2_exp + $signed(EW'(s2_prod[PW-1]));
        frac_c   = pn_c[PW-2 -: MAN_W];
        guard_c  = pn_c[PW-2-MAN_W];
        sticky_c = |pn_c[PW-3-MAN_W:0];
        rnd_up_c = guard_c && (sticky_c || frac_c[0]);
        {carry_c, fracr_c} = SW'(frac_c) + SW'(rnd_up_c);
        ef_c     = en_c + $signed(EW'(carry_c));
        ovf_c    = !ef_c[EW-1] && ($unsigned(ef_c) >= EW'(EXP_MAX));
        unf_c    = ef_c[EW-1] || (ef_c == '0);

        nan_c    = (s2_cls_a == CLS_NAN) || (s2_cls_b == CLS_NAN)
                || ((s2_cls_a == CLS_ZERO) && (s2_cls_b == CLS_INF))
                || ((s2_cls_a == CLS_INF) && (s2_cls_b == CLS_ZERO));
        inf_c    = (s2_cls_a == CLS_INF) || (s2_cls_b == CLS_INF);
        zero_c   = (s2_cls_a == CLS_ZERO) || (s2_cls_b == CLS_ZERO);
        normal_c = !nan_c && !inf_c && !zero_c;

        res_c = {s2_sign, ef_c[EXP_W-1:0], fracr_c};
        if (nan_c) begin
            res_c = W'(nan_word(EXP_W, MAN_W));
        end else if (inf_c || (normal_c && ovf_c)) begin
            res_c = W'(inf_word(s2_sign, EXP_W, MAN_W));
        end else if (zero_c || unf_c) begin
            res_c = {s2_sign, (W-1)'(0)};
        end
    end

    // Output register; out_res only changes when a real result lands
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= '0;
        end else if (adv_c) begin
            out_valid <= v2;
            if (v2) begin
                out_res <= res_c;
            end
        end
    end

`ifdef FP_MUL_FLAGS_EN
    logic [FLAG_W-1:0] flags_c;

    always_comb begin
        flags_c                 = '0;
        flags_c[FLAG_INVALID]   = nan_c;
        flags_c[FLAG_OVERFLOW]  = normal_c && ovf_c;
        flags_c[FLAG_UNDERFLOW] = normal_c && !ovf_c && unf_c;
        flags_c[FLAG_INEXACT]   = normal_c && (ovf_c || unf_c || guard_c || sticky_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_flags <= '0;
        end else if (adv_c && v2) begin
            out_flags <= flags_c;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe at half precision: directed vectors,
// randomized streaming against a real-arithmetic model, back-pressure, reset.
module tb_fp_mul_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    int checks = 0;
    int errors = 0;

    fp_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FP_MUL_FLAGS_EN
        .out_flags (out_flags),
`endif
        .out_res   (out_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Value-level model: exact real product, then RNE into a half-precision word
    function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic [3:0] f);
        int     ea, eb, fa, fb, e, be;
        logic   sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        real    m, sc, fr;
        longint ip;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        sign   = a[15] ^ b[15];
        a_zero = (ea == 0);  b_zero = (eb == 0);
        a_inf  = (ea == 31) && (fa == 0); b_inf = (eb == 31) && (fb == 0);
        a_nan  = (ea == 31) && (fa != 0); b_nan = (eb == 31) && (fb != 0);
        f = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            r = 16'h7E00;
            f = 4'b1000;
        end else if (a_inf || b_inf) begin
            r = {sign, 5'h1F, 10'h000};
        end else if (a_zero || b_zero) begin
            r = {sign, 15'h0000};
        end else begin
            m = (real'(1024 + fa) * real'(1024 + fb)) / 1048576.0;
            e = ea + eb - 30;
            while (m >= 2.0) begin
                m = m / 2.0;
                e = e + 1;
            end
            sc = m * 1024.0;
            ip = longint'($rtoi(sc));
            fr = sc - real'(ip);
            if (fr > 0.5 || (fr == 0.5 && ip[0])) ip = ip + 1;
            if (ip == 2048) begin
                ip = 1024;
                e  = e + 1;
            end
            be = e + 15;
            if (be >= 31) begin
                r = {sign, 5'h1F, 10'h000};
                f = 4'b0101;
            end else if (be <= 0) begin
                r = {sign, 15'h0000};
                f = 4'b0011;
            end else begin
                r = {sign, 5'(be), 10'(ip - 1024)};
                f = {3'b000, fr != 0.0};
            end
        end
    endfunction

    function automatic logic [15:0] rand_op();
        int unsigned sel;
        logic [15:0] v;
        sel = $urandom_range(0, 11);
        v   = 16'($urandom);
        if (sel == 0)      v[14:10] = 5'd0;
        else if (sel == 1) v[14:0]  = 15'h7C00;
        else if (sel == 2) v[14:10] = 5'h1F;
        else               v[14:10] = 5'($urandom_range(1, 30));
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_res !== 16'h0000) begin
            errors++; $display("FAIL reset_out_res: got %h want 0000", out_res);
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [9];
        logic [15:0] vb [9];
        logic [15:0] vr [9];
        logic [3:0]  vf [9];
        va = '{16'h3E00, 16'h3C01, 16'hBC00, 16'h7BFF, 16'h0400, 16'h8400, 16'h0000, 16'h7C01, 16'hFC00};
        vb = '{16'h4000, 16'h3C01, 16'h3C00, 16'h4000, 16'h0400, 16'h0400, 16'h7C00, 16'h3C00, 16'h4000};
        vr = '{16'h4200, 16'h3C02, 16'hBC00, 16'h7C00, 16'h0000, 16'h8000, 16'h7E00, 16'h7E00, 16'hFC00};
        vf = '{4'b0000,  4'b0001,  4'b0000,  4'b0101,  4'b0011,  4'b0011,  4'b1000,  4'b1000,  4'b0000};
        for (int i = 0; i < 9; i++) begin
            in_a = va[i]; in_b = vb[i]; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            step();
            in_valid = 1'b0;
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL dir_early_valid[%0d]: got %b want 0", i, out_valid);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_res !== vr[i]) begin
                errors++;
                $display("FAIL dir_result[%0d] %h x %h: got valid=%b res=%h want valid=1 res=%h",
                         i, va[i], vb[i], out_valid, out_res, vr[i]);
            end
`ifdef FP_MUL_FLAGS_EN
            checks++;
            if (out_flags !== vf[i]) begin
                errors++; $display("FAIL dir_flags[%0d]: got %b want %b", i, out_flags, vf[i]);
            end
`endif
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL dir_drain[%0d]: got %b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [19:0] q[$];
        logic [19:0] expv;
        logic [15:0] r;
        logic [3:0]  f;
        int          sent, got, cyc;
        const int    N = 400;
        sent = 0; got = 0; cyc = 0;
        while (got < N && cyc < 20000) begin
            in_valid = (sent < N) && ($urandom_range(0, 3) != 0);
            if (in_valid) begin
                in_a = rand_op();
                in_b = rand_op();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                ref_mul(in_a, in_b, r, f);
                q.push_back({f, r});
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: got res=%h want no result", out_res);
                end else begin
                    expv = q.pop_front();
                    if (out_res !== expv[15:0]) begin
                        errors++; $display("FAIL rand_res[%0d]: got %h want %h", got, out_res, expv[15:0]);
                    end
`ifdef FP_MUL_FLAGS_EN
                    checks++;
                    if (out_flags !== expv[19:16]) begin
                        errors++; $display("FAIL rand_flags[%0d]: got %b want %b", got, out_flags, expv[19:16]);
                    end
`endif
                end
                got++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got != N) begin
            errors++; $display("FAIL rand_count: got %0d results want %0d", got, N);
        end
        step(); step(); step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [5];
        logic [15:0] tb [5];
        logic [15:0] er [5];
        logic [3:0]  ef;
        logic [15:0] held;
        int          idx, got, cyc, stall_left;
        for (int i = 0; i < 5; i++) begin
            ta[i] = {1'b0, 5'($urandom_range(12, 18)), 10'($urandom)};
            tb[i] = {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
            ref_mul(ta[i], tb[i], er[i], ef);
        end
        idx = 0; got = 0; cyc = 0; stall_left = -1; held = '0;
        while (got < 5 && cyc < 60) begin
            in_valid = (idx < 5);
            if (idx < 5) begin
                in_a = ta[idx];
                in_b = tb[idx];
            end
            if (out_valid && stall_left < 0) begin
                stall_left = 4;
                held = out_res;
            end
            out_ready = !(stall_left > 0);
            #1;
            if (stall_left > 0) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_stall_ready: got in_ready=%b out_valid=%b want 0,1", in_ready, out_valid);
                end
                checks++;
                if (out_res !== held) begin
                    errors++; $display("FAIL bp_hold: got %h want %h", out_res, held);
                end
                stall_left--;
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                checks++;
                if (got >= 5 || out_res !== er[got]) begin
                    errors++; $display("FAIL bp_order[%0d]: got %h want %h", got, out_res, er[got % 5]);
                end
                got++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got != 5 || idx != 5) begin
            errors++; $display("FAIL bp_count: got %0d results %0d issued want 5 5", got, idx);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL bp_duplicate: got out_valid=%b res=%h want 0", out_valid, out_res);
            end
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'h4200; in_b = 16'h4400;
        step();
        in_a = 16'hC500; in_b = 16'h3E00;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_res !== 16'h0000) begin
            errors++; $display("FAIL rst_flush: got valid=%b res=%h want 0 0000", out_valid, out_res);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL rst_stale[%0d]: got valid=%b res=%h want 0", i, out_valid, out_res);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
